// File: rtl/cc_psr_condition_unit_if.sv
// Bus bundle between the control unit (master) and the PSR condition unit (slave).
// Signal names match the original flat port list so existing hookups translate one-to-one.
interface cc_psr_condition_unit_if #(
  parameter int unsigned DATAWIDTH_BUS = 32
);
  logic                     CC_PSR_negative_InLow;
  logic                     CC_PSR_zero_InLow;
  logic                     CC_PSR_overflow_InLow;
  logic                     CC_PSR_carry_InLow;
  logic                     CC_PSR_setCC_In;
  logic                     CC_PSR_enable_In;
  logic                     CC_PSR_wrpsr_In;
  logic [DATAWIDTH_BUS-1:0] CC_PSR_data_InBUS;
  logic [3:0]               CC_PSR_cond_InBUS;
  logic                     CC_PSR_evaluate_In;
  logic [3:0]               CC_PSR_icc_OutBUS;
  logic [DATAWIDTH_BUS-1:0] CC_PSR_data_OutBUS;
  logic                     CC_PSR_busy_Out;
  logic                     CC_PSR_valid_Out;
  logic                     CC_PSR_taken_Out;

  modport master (
    output CC_PSR_negative_InLow, CC_PSR_zero_InLow, CC_PSR_overflow_InLow, CC_PSR_carry_InLow,
    output CC_PSR_setCC_In, CC_PSR_enable_In, CC_PSR_wrpsr_In, CC_PSR_data_InBUS,
    output CC_PSR_cond_InBUS, CC_PSR_evaluate_In,
    input  CC_PSR_icc_OutBUS, CC_PSR_data_OutBUS, CC_PSR_busy_Out, CC_PSR_valid_Out,
    input  CC_PSR_taken_Out
  );

  modport slave (
    input  CC_PSR_negative_InLow, CC_PSR_zero_InLow, CC_PSR_overflow_InLow, CC_PSR_carry_InLow,
    input  CC_PSR_setCC_In, CC_PSR_enable_In, CC_PSR_wrpsr_In, CC_PSR_data_InBUS,
    input  CC_PSR_cond_InBUS, CC_PSR_evaluate_In,
    output CC_PSR_icc_OutBUS, CC_PSR_data_OutBUS, CC_PSR_busy_Out, CC_PSR_valid_Out,
    output CC_PSR_taken_Out
  );
endinterface

// File: rtl/cc_psr_condition_unit.sv
// PSR integer condition-code register with WRPSR/RDPSR access and a registered
// SPARC branch-condition evaluator (request/valid handshake, flag-write hazard stall).
module cc_psr_condition_unit #(
  parameter int unsigned DATAWIDTH_BUS = 32,
  parameter int unsigned ICC_LSB       = 20
) (
  input logic                  CC_PSR_CLOCK_50,
  input logic                  CC_PSR_RESET_InHigh,
  cc_psr_condition_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, HOLD, RESULT} state_t;

  state_t     state, state_next;
  logic [3:0] icc;
  logic [3:0] cond, cond_next;
  logic       taken_held, taken_next;
  logic       valid, busy;
  logic       cc_commit, flag_wr;
  logic [DATAWIDTH_BUS-1:0] psr_image;
  logic       unused_data;

  assign cc_commit = bus.CC_PSR_setCC_In & bus.CC_PSR_enable_In;
  assign flag_wr   = cc_commit | bus.CC_PSR_wrpsr_In;
  // Only the icc field of the WRPSR source is architecturally used here.
  assign unused_data = ^bus.CC_PSR_data_InBUS;

  function automatic logic branch_taken(input logic [3:0] c, input logic [3:0] f);
    logic n, z, v, cy, base;
    {n, z, v, cy} = f;
    unique case (c[2:0])
      3'd0:    base = 1'b0;
      3'd1:    base = z;
      3'd2:    base = z | (n ^ v);
      3'd3:    base = n ^ v;
      3'd4:    base = cy | z;
      3'd5:    base = cy;
      3'd6:    base = n;
      default: base = v;
    endcase
    // Upper half of the encoding is the complement of the lower half (BN <-> BA).
    return c[3] ^ base;
  endfunction

  always_ff @(posedge CC_PSR_CLOCK_50 or posedge CC_PSR_RESET_InHigh) begin
    if (CC_PSR_RESET_InHigh) begin
      icc <= '0;
    end else if (bus.CC_PSR_wrpsr_In) begin
      icc <= bus.CC_PSR_data_InBUS[ICC_LSB +: 4];
    end else if (cc_commit) begin
      icc <= ~{bus.CC_PSR_negative_InLow, bus.CC_PSR_zero_InLow,
               bus.CC_PSR_overflow_InLow, bus.CC_PSR_carry_InLow};
    end
  end

  always_ff @(posedge CC_PSR_CLOCK_50 or posedge CC_PSR_RESET_InHigh) begin
    if (CC_PSR_RESET_InHigh) begin
      state      <= IDLE;
      cond       <= '0;
      taken_held <= 1'b0;
    end else begin
      state      <= state_next;
      cond       <= cond_next;
      taken_held <= taken_next;
    end
  end

  always_comb begin
    state_next = state;
    cond_next  = cond;
    taken_next = taken_held;
    valid      = 1'b0;
    busy       = (state != IDLE);
    unique case (state)
      IDLE: begin
        if (bus.CC_PSR_evaluate_In) begin
          cond_next = bus.CC_PSR_cond_InBUS;
          // A same-cycle flag write stalls one cycle so RESULT sees the new icc.
          state_next = flag_wr ? HOLD : RESULT;
        end
      end
      HOLD: state_next = RESULT;
      RESULT: begin
        valid      = 1'b1;
        taken_next = branch_taken(cond, icc);
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    psr_image              = '0;
    psr_image[ICC_LSB +: 4] = icc;
  end

  assign bus.CC_PSR_icc_OutBUS  = icc;
  assign bus.CC_PSR_data_OutBUS = psr_image;
  assign bus.CC_PSR_busy_Out    = busy;
  assign bus.CC_PSR_valid_Out   = valid;
  assign bus.CC_PSR_taken_Out   = taken_next;

endmodule

// File: tb/tb_cc_psr_condition_unit.sv
// Bench for cc_psr_condition_unit: cycle model compared every cycle plus directed literal checks.
module tb_cc_psr_condition_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   vcount = 0;
  bit   cmp_on = 1'b0;

  always #5 clk = ~clk;

  cc_psr_condition_unit_if #(.DATAWIDTH_BUS(32)) bus ();

  cc_psr_condition_unit #(.DATAWIDTH_BUS(32), .ICC_LSB(20)) dut (
    .CC_PSR_CLOCK_50     (clk),
    .CC_PSR_RESET_InHigh (rst),
    .bus                 (bus)
  );

  // Reference: written from the mnemonic table, one entry per condition.
  function automatic bit ref_branch(input logic [3:0] c, input logic [3:0] f);
    bit n, z, v, cy;
    n = f[3]; z = f[2]; v = f[1]; cy = f[0];
    case (c)
      4'd0:  return 1'b0;
      4'd1:  return z;
      4'd2:  return z | (n ^ v);
      4'd3:  return n ^ v;
      4'd4:  return cy | z;
      4'd5:  return cy;
      4'd6:  return n;
      4'd7:  return v;
      4'd8:  return 1'b1;
      4'd9:  return !z;
      4'd10: return !(z | (n ^ v));
      4'd11: return !(n ^ v);
      4'd12: return !(cy | z);
      4'd13: return !cy;
      4'd14: return !n;
      default: return !v;
    endcase
  endfunction

  // Model: icc value, cycles left until the answer (0 = free), latched cond, last answer.
  logic [3:0] m_icc, m_cond;
  int         m_left;
  bit         m_taken;
  wire        m_fw = (bus.CC_PSR_setCC_In && bus.CC_PSR_enable_In) || bus.CC_PSR_wrpsr_In;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_icc <= 4'h0; m_cond <= 4'h0; m_left <= 0; m_taken <= 1'b0;
    end else begin
      if (m_left == 1) m_taken <= ref_branch(m_cond, m_icc);
      if (m_left == 0 && bus.CC_PSR_evaluate_In) begin
        m_cond <= bus.CC_PSR_cond_InBUS;
        m_left <= m_fw ? 2 : 1;
      end else if (m_left > 0) begin
        m_left <= m_left - 1;
      end
      if (bus.CC_PSR_wrpsr_In) m_icc <= bus.CC_PSR_data_InBUS[23:20];
      else if (m_fw) m_icc <= ~{bus.CC_PSR_negative_InLow, bus.CC_PSR_zero_InLow,
                                bus.CC_PSR_overflow_InLow, bus.CC_PSR_carry_InLow};
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.CC_PSR_valid_Out === 1'b1) vcount++;
      if (cmp_on) begin
        chk("m_icc",   {28'h0, bus.CC_PSR_icc_OutBUS}, {28'h0, m_icc});
        chk("m_data",  bus.CC_PSR_data_OutBUS, {8'h00, m_icc, 20'h00000});
        chk("m_busy",  {31'h0, bus.CC_PSR_busy_Out},  {31'h0, m_left > 0});
        chk("m_valid", {31'h0, bus.CC_PSR_valid_Out}, {31'h0, m_left == 1});
        chk("m_taken", {31'h0, bus.CC_PSR_taken_Out},
            {31'h0, (m_left == 1) ? ref_branch(m_cond, m_icc) : m_taken});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic set_inlow(input logic [3:0] nzvc_low);
    {bus.CC_PSR_negative_InLow, bus.CC_PSR_zero_InLow,
     bus.CC_PSR_overflow_InLow, bus.CC_PSR_carry_InLow} = nzvc_low;
  endtask

  task automatic write_icc(input logic [3:0] v);
    bus.CC_PSR_wrpsr_In   = 1'b1;
    bus.CC_PSR_data_InBUS = {8'h00, v, 20'h00000};
    cyc();
    bus.CC_PSR_wrpsr_In   = 1'b0;
  endtask

  task automatic eval_check(input string name, input logic [3:0] c, input bit exp);
    bus.CC_PSR_cond_InBUS  = c;
    bus.CC_PSR_evaluate_In = 1'b1;
    cyc();
    bus.CC_PSR_evaluate_In = 1'b0;
    chk({name, "_valid"}, {31'h0, bus.CC_PSR_valid_Out}, 32'd1);
    chk({name, "_taken"}, {31'h0, bus.CC_PSR_taken_Out}, {31'h0, exp});
    cyc();
  endtask

  initial begin
    int v0;
    set_inlow(4'hF);
    bus.CC_PSR_setCC_In    = 1'b0;
    bus.CC_PSR_enable_In   = 1'b0;
    bus.CC_PSR_wrpsr_In    = 1'b0;
    bus.CC_PSR_data_InBUS  = '0;
    bus.CC_PSR_cond_InBUS  = 4'h0;
    bus.CC_PSR_evaluate_In = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
    cmp_on = 1'b1;
    chk("rst_icc",   {28'h0, bus.CC_PSR_icc_OutBUS}, 32'h0);
    chk("rst_data",  bus.CC_PSR_data_OutBUS, 32'h0);
    chk("rst_busy",  {31'h0, bus.CC_PSR_busy_Out}, 32'h0);
    chk("rst_valid", {31'h0, bus.CC_PSR_valid_Out}, 32'h0);
    chk("rst_taken", {31'h0, bus.CC_PSR_taken_Out}, 32'h0);

    // Commit with all flags asserted (active low inputs at 0).
    set_inlow(4'h0);
    bus.CC_PSR_setCC_In = 1'b1; bus.CC_PSR_enable_In = 1'b1;
    cyc();
    bus.CC_PSR_enable_In = 1'b0;
    chk("t1_icc",  {28'h0, bus.CC_PSR_icc_OutBUS}, 32'hF);
    chk("t1_data", bus.CC_PSR_data_OutBUS, 32'h00F00000);

    // setCC without enable must not write.
    set_inlow(4'hF);
    cyc();
    chk("t2_noen", {28'h0, bus.CC_PSR_icc_OutBUS}, 32'hF);
    bus.CC_PSR_setCC_In = 1'b0;
    write_icc(4'b0100);
    chk("t2_wrpsr", {28'h0, bus.CC_PSR_icc_OutBUS}, 32'h4);

    // WRPSR wins over a simultaneous commit.
    bus.CC_PSR_setCC_In = 1'b1; bus.CC_PSR_enable_In = 1'b1; set_inlow(4'h0);
    write_icc(4'b0110);
    bus.CC_PSR_setCC_In = 1'b0; bus.CC_PSR_enable_In = 1'b0; set_inlow(4'hF);
    chk("t2_prio", {28'h0, bus.CC_PSR_icc_OutBUS}, 32'h6);
    write_icc(4'b0100);

    // No-hazard evaluation: answer one cycle after the request edge, then held.
    eval_check("t3_be", 4'b0001, 1'b1);
    chk("t3_hold", {31'h0, bus.CC_PSR_taken_Out}, 32'd1);
    chk("t3_idle", {31'h0, bus.CC_PSR_busy_Out}, 32'd0);
    eval_check("t3_bne", 4'b1001, 1'b0);

    // Hazard: evaluation issued with a commit that clears z.
    bus.CC_PSR_cond_InBUS = 4'b0001; bus.CC_PSR_evaluate_In = 1'b1;
    bus.CC_PSR_setCC_In = 1'b1; bus.CC_PSR_enable_In = 1'b1; set_inlow(4'hF);
    cyc();
    bus.CC_PSR_evaluate_In = 1'b0; bus.CC_PSR_setCC_In = 1'b0; bus.CC_PSR_enable_In = 1'b0;
    chk("t4_busy1",  {31'h0, bus.CC_PSR_busy_Out}, 32'd1);
    chk("t4_valid1", {31'h0, bus.CC_PSR_valid_Out}, 32'd0);
    cyc();
    chk("t4_busy2",  {31'h0, bus.CC_PSR_busy_Out}, 32'd1);
    chk("t4_valid2", {31'h0, bus.CC_PSR_valid_Out}, 32'd1);
    chk("t4_taken",  {31'h0, bus.CC_PSR_taken_Out}, 32'd0);
    cyc();
    chk("t4_done",   {31'h0, bus.CC_PSR_busy_Out}, 32'd0);

    // n=1, v=0.
    write_icc(4'b1000);
    eval_check("t5_bl",  4'b0011, 1'b1);
    eval_check("t5_bge", 4'b1011, 1'b0);
    eval_check("t5_ba",  4'b1000, 1'b1);
    eval_check("t5_bn",  4'b0000, 1'b0);

    // Requests held high while busy produce exactly one answer.
    v0 = vcount;
    bus.CC_PSR_cond_InBUS = 4'b0110; bus.CC_PSR_evaluate_In = 1'b1;
    bus.CC_PSR_setCC_In = 1'b1; bus.CC_PSR_enable_In = 1'b1; set_inlow(4'b0111);
    cyc();
    bus.CC_PSR_setCC_In = 1'b0; bus.CC_PSR_enable_In = 1'b0; set_inlow(4'hF);
    cyc(); cyc();
    bus.CC_PSR_evaluate_In = 1'b0;
    cyc(); cyc(); cyc();
    chk("t5_onepulse", vcount - v0, 32'd1);

    // Model sweep over every condition for two flag patterns, with a commit during RESULT.
    for (int unsigned p = 0; p < 2; p++) begin
      write_icc(p == 0 ? 4'b0101 : 4'b1010);
      for (int unsigned c = 0; c < 16; c++) begin
        bus.CC_PSR_cond_InBUS  = 4'(c);
        bus.CC_PSR_evaluate_In = 1'b1;
        cyc();
        bus.CC_PSR_evaluate_In = 1'b0;
        bus.CC_PSR_setCC_In = (c == 4); bus.CC_PSR_enable_In = (c == 4);
        set_inlow(4'hF);
        cyc();
        bus.CC_PSR_setCC_In = 1'b0; bus.CC_PSR_enable_In = 1'b0;
        if (c == 4) write_icc(p == 0 ? 4'b0101 : 4'b1010);
      end
    end

    // Reset while in HOLD: no answer ever appears.
    bus.CC_PSR_cond_InBUS = 4'b1000; bus.CC_PSR_evaluate_In = 1'b1;
    bus.CC_PSR_wrpsr_In = 1'b1; bus.CC_PSR_data_InBUS = 32'h00F00000;
    cyc();
    bus.CC_PSR_evaluate_In = 1'b0; bus.CC_PSR_wrpsr_In = 1'b0;
    chk("t6_hold", {31'h0, bus.CC_PSR_busy_Out}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("t6_icc",   {28'h0, bus.CC_PSR_icc_OutBUS}, 32'h0);
    chk("t6_busy",  {31'h0, bus.CC_PSR_busy_Out}, 32'd0);
    chk("t6_valid", {31'h0, bus.CC_PSR_valid_Out}, 32'd0);
    v0 = vcount;
    cyc();
    rst = 1'b0;
    cyc(); cyc(); cyc(); cyc();
    chk("t6_novalid", vcount - v0, 32'd0);
    chk("t6_icc_after", {28'h0, bus.CC_PSR_icc_OutBUS}, 32'h0);

    cmp_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
